// File: rtl/rr_bus_interconnect.sv
// Round-robin shared-path bus interconnect: NUM_MASTERS request/finish masters to
// NUM_SLAVES base/mask-decoded slaves, with decode-miss and timeout error completion.
module rr_bus_interconnect #(
   parameter int                                  NUM_MASTERS    = 2,
   parameter int                                  NUM_SLAVES     = 3,
   parameter int                                  BUS_WIDTH      = 256,
   parameter int                                  ADDR_WIDTH     = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLAVE_BASE     = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]    SLAVE_MASK     = {3{32'hF000_0000}},
   parameter int unsigned                         TIMEOUT_CYCLES = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_addr,
   input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  master_write_data,
   input  logic [NUM_MASTERS-1:0]            master_read_request,
   input  logic [NUM_MASTERS-1:0]            master_write_request,
   output logic [NUM_MASTERS-1:0]            master_request_finish,
   output logic [NUM_MASTERS-1:0]            master_error,
   output logic [NUM_MASTERS*BUS_WIDTH-1:0]  master_read_data,
   output logic [ADDR_WIDTH-1:0]             slave_addr,
   output logic [BUS_WIDTH-1:0]              slave_write_data,
   output logic [NUM_SLAVES-1:0]             slave_read_request,
   output logic [NUM_SLAVES-1:0]             slave_write_request,
   input  logic [NUM_SLAVES-1:0]             slave_request_finish,
   input  logic [NUM_SLAVES*BUS_WIDTH-1:0]   slave_read_data
);

   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SW = (NUM_SLAVES  > 1) ? $clog2(NUM_SLAVES)  : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t                                   state_q, state_d;
   logic [MW-1:0]                            last_q, last_d;
   logic [MW-1:0]                            grant_q, grant_d;
   logic [SW-1:0]                            sel_q, sel_d;
   logic [ADDR_WIDTH-1:0]                    addr_q, addr_d;
   logic [BUS_WIDTH-1:0]                     wdata_q, wdata_d;
   logic                                     rd_q, rd_d;
   logic                                     wr_q, wr_d;
   logic                                     err_q, err_d;
   logic [31:0]                              cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0][BUS_WIDTH-1:0]    lane_q, lane_d;

   logic [NUM_MASTERS-1:0] pend;
   logic                   found;
   logic [MW-1:0]          arb_idx;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic [BUS_WIDTH-1:0]   req_wdata;
   logic                   req_rd, req_wr;
   logic                   hit;
   logic [SW-1:0]          dec_sel;
   logic                   sel_fin;
   logic [BUS_WIDTH-1:0]   sel_rdata;

   assign pend = master_read_request | master_write_request;

   // Search starts one past the last grant so every pending master is reached within NUM_MASTERS grants.
   always_comb begin
      int idx;
      found   = 1'b0;
      arb_idx = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = (int'(last_q) + k) % NUM_MASTERS;
         for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!found && j == idx && pend[j]) begin
               found   = 1'b1;
               arb_idx = MW'(j);
            end
         end
      end
   end

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      req_rd    = 1'b0;
      req_wr    = 1'b0;
      for (int j = 0; j < NUM_MASTERS; j++) begin
         if (MW'(j) == arb_idx) begin
            req_addr  = master_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            req_wdata = master_write_data[j*BUS_WIDTH +: BUS_WIDTH];
            req_rd    = master_read_request[j];
            req_wr    = master_write_request[j];
         end
      end
   end

   // Walk downwards so the lowest matching window is the one left standing.
   always_comb begin
      hit     = 1'b0;
      dec_sel = '0;
      for (int s = NUM_SLAVES-1; s >= 0; s--) begin
         if ((req_addr & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit     = 1'b1;
            dec_sel = SW'(s);
         end
      end
   end

   always_comb begin
      sel_fin   = 1'b0;
      sel_rdata = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (SW'(s) == sel_q) begin
            sel_fin   = slave_request_finish[s];
            sel_rdata = slave_read_data[s*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      lane_d  = lane_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = arb_idx;
               last_d  = arb_idx;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rd_d    = req_rd;
               wr_d    = req_wr;
               sel_d   = dec_sel;
               cnt_d   = '0;
               if (hit) begin
                  state_d = S_BUSY;
                  err_d   = 1'b0;
               end else begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  for (int j = 0; j < NUM_MASTERS; j++)
                     if (MW'(j) == arb_idx) lane_d[j] = '0;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 32'd1;
            if (sel_fin) begin
               state_d = S_RESP;
               err_d   = 1'b0;
               for (int j = 0; j < NUM_MASTERS; j++)
                  if (rd_q && MW'(j) == grant_q) lane_d[j] = sel_rdata;
            end else if (TIMEOUT_CYCLES != 0 && cnt_d == TIMEOUT_CYCLES) begin
               state_d = S_RESP;
               err_d   = 1'b1;
               for (int j = 0; j < NUM_MASTERS; j++)
                  if (MW'(j) == grant_q) lane_d[j] = '0;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         last_q  <= MW'(NUM_MASTERS-1);
         grant_q <= '0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
      end
   end

   always_comb begin
      slave_read_request    = '0;
      slave_write_request   = '0;
      master_request_finish = '0;
      master_error          = '0;
      if (state_q == S_BUSY) begin
         for (int s = 0; s < NUM_SLAVES; s++) begin
            if (SW'(s) == sel_q) begin
               slave_read_request[s]  = rd_q;
               slave_write_request[s] = wr_q;
            end
         end
      end
      if (state_q == S_RESP) begin
         for (int j = 0; j < NUM_MASTERS; j++) begin
            if (MW'(j) == grant_q) begin
               master_request_finish[j] = 1'b1;
               master_error[j]          = err_q;
            end
         end
      end
   end

   assign slave_addr       = addr_q;
   assign slave_write_data = wdata_q;
   assign master_read_data = lane_q;

endmodule

// File: tb/tb_rr_bus_interconnect.sv
// Directed bench for rr_bus_interconnect: read, fairness, write, decode miss,
// timeout and reset-during-BUSY scenarios with hand-computed expectations.
module tb_rr_bus_interconnect;

   localparam int NM = 2;
   localparam int NS = 3;
   localparam int BW = 256;
   localparam int AW = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic [NM*AW-1:0]    master_addr;
   logic [NM*BW-1:0]    master_write_data;
   logic [NM-1:0]       mrr, mwr, mrf, merr;
   logic [NM*BW-1:0]    mrd;
   logic [AW-1:0]       slave_addr;
   logic [BW-1:0]       swd;
   logic [NS-1:0]       srr, swr, sfin;
   logic [NS*BW-1:0]    srd;

   int n_tests = 0;
   int n_fail  = 0;

   logic [BW-1:0] dat_a5, dat_y, dat_z;

   rr_bus_interconnect #(
      .NUM_MASTERS(NM), .NUM_SLAVES(NS), .BUS_WIDTH(BW), .ADDR_WIDTH(AW),
      .SLAVE_BASE({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
      .SLAVE_MASK({3{32'hF000_0000}}),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .master_addr(master_addr), .master_write_data(master_write_data),
      .master_read_request(mrr), .master_write_request(mwr),
      .master_request_finish(mrf), .master_error(merr), .master_read_data(mrd),
      .slave_addr(slave_addr), .slave_write_data(swd),
      .slave_read_request(srr), .slave_write_request(swr),
      .slave_request_finish(sfin), .slave_read_data(srd)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_all;
      mrr  = '0;
      mwr  = '0;
      sfin = '0;
      step();
   endtask

   task automatic test_reset;
      rst = 1'b0;
      master_addr = '0; master_write_data = '0; mrr = '0; mwr = '0; sfin = '0; srd = '0;
      step(); step();
      n_tests++;
      if ((mrf | merr) !== '0) begin n_fail++; $display("FAIL reset_finish_err: got %b/%b exp 0", mrf, merr); end
      n_tests++;
      if (mrd !== '0) begin n_fail++; $display("FAIL reset_lanes: got %h exp 0", mrd); end
      n_tests++;
      if (slave_addr !== '0 || swd !== '0) begin n_fail++; $display("FAIL reset_slave_bus: got %h/%h exp 0", slave_addr, swd); end
      n_tests++;
      if ((srr | swr) !== '0) begin n_fail++; $display("FAIL reset_slave_req: got %b/%b exp 0", srr, swr); end
      #2 rst = 1'b1;
      step();
   endtask

   task automatic test_single_read;
      int busy = 0;
      bit got = 0;
      master_addr[AW +: AW] = 32'h1000_0040;
      srd[BW +: BW] = dat_a5;
      mrr[1] = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         step();
         if (srr[1]) begin
            busy++;
            if (slave_addr !== 32'h1000_0040) begin n_fail++; $display("FAIL read_addr: got %h exp 10000040", slave_addr); end
            n_tests++;
            if (busy == 3) sfin[1] = 1'b1;
         end
         if (mrf[1]) got = 1;
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL read_finish: got none exp pulse"); end
      n_tests++;
      if (busy != 3) begin n_fail++; $display("FAIL read_busy_cycles: got %0d exp 3", busy); end
      n_tests++;
      if (merr !== 2'b00 || mrf !== 2'b10 || srr !== 3'b000) begin n_fail++; $display("FAIL read_resp: got fin %b err %b srr %b exp 10/00/000", mrf, merr, srr); end
      n_tests++;
      if (mrd[BW +: BW] !== dat_a5) begin n_fail++; $display("FAIL read_lane1: got %h exp %h", mrd[BW +: BW], dat_a5); end
      n_tests++;
      if (mrd[0 +: BW] !== '0) begin n_fail++; $display("FAIL read_lane0: got %h exp 0", mrd[0 +: BW]); end
      drop_all();
      n_tests++;
      if (mrf !== 2'b00) begin n_fail++; $display("FAIL read_pulse_width: got %b exp 00", mrf); end
   endtask

   task automatic test_fairness;
      int np = 0;
      int at [4];
      logic [3:0] who = '0;
      master_addr[0 +: AW]  = 32'h0000_0100;
      master_addr[AW +: AW] = 32'h0000_0200;
      srd[0 +: BW] = dat_y;
      sfin[0] = 1'b1;
      mrr = 2'b11;
      for (int c = 0; c < 30 && np < 4; c++) begin
         step();
         if (mrf != 2'b00) begin
            who[np] = mrf[1];
            at[np]  = c;
            np++;
         end
      end
      n_tests++;
      if (np != 4) begin n_fail++; $display("FAIL fair_pulses: got %0d exp 4", np); end
      else begin
         n_tests++;
         if (who !== 4'b1010) begin n_fail++; $display("FAIL fair_order: got %b exp 1010 (bit i = master of grant i)", who); end
         n_tests++;
         if (at[1]-at[0] != 3 || at[2]-at[0] != 6 || at[3]-at[1] != 6) begin
            n_fail++; $display("FAIL fair_spacing: got %0d %0d %0d %0d exp step 3", at[0], at[1], at[2], at[3]);
         end
      end
      n_tests++;
      if (mrd !== {dat_y, dat_y}) begin n_fail++; $display("FAIL fair_lanes: got %h exp both %h", mrd, dat_y); end
      drop_all();
   endtask

   task automatic test_write;
      bit got = 0;
      bit seen = 0;
      master_addr[AW +: AW] = 32'h2000_0000;
      master_write_data[BW +: BW] = 256'h1234;
      srd[2*BW +: BW] = 256'hDEAD;
      mwr[1] = 1'b1;
      for (int c = 0; c < 10 && !got; c++) begin
         step();
         if (swr[2] && !seen) begin
            seen = 1;
            n_tests++;
            if (swr !== 3'b100 || srr !== 3'b000) begin n_fail++; $display("FAIL write_req: got swr %b srr %b exp 100/000", swr, srr); end
            n_tests++;
            if (slave_addr !== 32'h2000_0000 || swd !== 256'h1234) begin n_fail++; $display("FAIL write_bus: got %h %h exp 20000000 1234", slave_addr, swd); end
            sfin[2] = 1'b1;
         end
         if (mrf[1]) got = 1;
      end
      n_tests++;
      if (!got || !seen) begin n_fail++; $display("FAIL write_done: got seen=%0d fin=%0d exp 1/1", seen, got); end
      n_tests++;
      if (merr !== 2'b00) begin n_fail++; $display("FAIL write_err: got %b exp 00", merr); end
      n_tests++;
      if (mrd[BW +: BW] !== dat_y) begin n_fail++; $display("FAIL write_lane1: got %h exp %h", mrd[BW +: BW], dat_y); end
      drop_all();
   endtask

   task automatic test_decode_miss;
      master_addr[0 +: AW] = 32'h3000_0000;
      mrr[0] = 1'b1;
      step();
      n_tests++;
      if (mrf !== 2'b01 || merr !== 2'b01) begin n_fail++; $display("FAIL miss_finish: got fin %b err %b exp 01/01", mrf, merr); end
      n_tests++;
      if ((srr | swr) !== '0) begin n_fail++; $display("FAIL miss_slave_req: got %b/%b exp 0", srr, swr); end
      n_tests++;
      if (mrd[0 +: BW] !== '0) begin n_fail++; $display("FAIL miss_lane0: got %h exp 0", mrd[0 +: BW]); end
      n_tests++;
      if (mrd[BW +: BW] !== dat_y) begin n_fail++; $display("FAIL miss_lane1: got %h exp %h", mrd[BW +: BW], dat_y); end
      drop_all();
      n_tests++;
      if ((mrf | merr | srr | swr) !== '0) begin n_fail++; $display("FAIL miss_after: got %b %b %b %b exp 0", mrf, merr, srr, swr); end
   endtask

   task automatic test_timeout;
      int hi = 0;
      bit got = 0;
      master_addr[AW +: AW] = 32'h2000_0010;
      srd[2*BW +: BW] = 256'hBEEF;
      mrr[1] = 1'b1;
      for (int c = 0; c < 40 && !got; c++) begin
         step();
         if (srr[2]) hi++;
         if (mrf[1]) got = 1;
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL timeout_finish: got none exp pulse"); end
      n_tests++;
      if (hi != 8) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d exp 8", hi); end
      n_tests++;
      if (merr !== 2'b10) begin n_fail++; $display("FAIL timeout_err: got %b exp 10", merr); end
      n_tests++;
      if (mrd !== '0) begin n_fail++; $display("FAIL timeout_lanes: got %h exp 0", mrd); end
      drop_all();
   endtask

   task automatic test_reset_mid_busy;
      bit got = 0;
      master_addr[0 +: AW] = 32'h1000_0000;
      mrr[0] = 1'b1;
      step(); step();
      n_tests++;
      if (srr !== 3'b010) begin n_fail++; $display("FAIL rmb_busy: got %b exp 010", srr); end
      rst = 1'b0;
      #1;
      n_tests++;
      if ((srr | swr) !== '0 || (mrf | merr) !== '0 || slave_addr !== '0) begin
         n_fail++; $display("FAIL rmb_outputs: got srr %b swr %b fin %b err %b addr %h exp 0", srr, swr, mrf, merr, slave_addr);
      end
      master_addr[0 +: AW]  = 32'h0000_0040;
      master_addr[AW +: AW] = 32'h0000_0080;
      srd[0 +: BW] = dat_z;
      sfin[0] = 1'b1;
      mrr = 2'b11;
      step();
      n_tests++;
      if (mrf !== 2'b00) begin n_fail++; $display("FAIL rmb_no_finish: got %b exp 00", mrf); end
      #2 rst = 1'b1;
      for (int c = 0; c < 10 && !got; c++) begin
         step();
         if (mrf != 2'b00) got = 1;
      end
      n_tests++;
      if (mrf !== 2'b01) begin n_fail++; $display("FAIL rmb_first_grant: got %b exp 01", mrf); end
      n_tests++;
      if (mrd[0 +: BW] !== dat_z) begin n_fail++; $display("FAIL rmb_lane0: got %h exp %h", mrd[0 +: BW], dat_z); end
      drop_all();
   endtask

   initial begin
      dat_a5 = {32{8'hA5}};
      dat_y  = {4{64'h0123_4567_89AB_CDEF}};
      dat_z  = {8{32'h5A5A_C3C3}};
      test_reset();
      test_single_read();
      test_fairness();
      test_write();
      test_decode_miss();
      test_timeout();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
